reduce_param: RTL and testbench

- Parametrised column reduction engine. It reduces an ROWS x COLS matrix to one COLS-entry vector, one column at a time.
- Four modes are selectable per run: truncating mean, rounded mean, maximum and saturated sum.
- It has a start/busy/done handshake and optional signed arithmetic.
- It sits between feature-map stages of the classifier datapath, where a column-pooling step is needed.

---
 rtl/reduce_pkg.sv | 27 ++
 rtl/reduce_acc.sv | 81 ++++++++
 rtl/reduce_param.sv | 118 +++++++++++
 tb/tb_reduce_param.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reduce_pkg: shared mode/state types for the column reduction engine. Rev 1.0
// ---------------------------------------------------------------------------
package reduce_pkg;

  localparam logic [1:0] c_MODE_MEAN_TRUNC = 2'd0;
  localparam logic [1:0] c_MODE_MEAN_RND   = 2'd1;
  localparam logic [1:0] c_MODE_MAX        = 2'd2;
  localparam logic [1:0] c_MODE_SUM_SAT    = 2'd3;

  typedef enum logic [1:0] {
    MODE_MEAN_TRUNC = c_MODE_MEAN_TRUNC,
    MODE_MEAN_RND   = c_MODE_MEAN_RND,
    MODE_MAX        = c_MODE_MAX,
    MODE_SUM_SAT    = c_MODE_SUM_SAT
  } reduce_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } reduce_state_t;

endpackage
`default_nettype wire

// File: rtl/reduce_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reduce_acc: per-column accumulator with mean/round/max/saturate result. Rev 1.0
// ---------------------------------------------------------------------------
module reduce_acc
  import reduce_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ROWS   = 16,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  reduce_mode_t      mode,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] result
);
  localparam int c_SHIFT = $clog2(ROWS);
  localparam int c_ACC_W = DATA_W + c_SHIFT + 1;
  localparam logic signed [c_ACC_W-1:0] c_HALF = c_ACC_W'(ROWS / 2);
  localparam logic signed [c_ACC_W-1:0] c_SAT_HI = (SIGNED != 0)
      ? ((c_ACC_W'(1) << (DATA_W - 1)) - c_ACC_W'(1))
      : ((c_ACC_W'(1) << DATA_W) - c_ACC_W'(1));
  localparam logic signed [c_ACC_W-1:0] c_SAT_LO = (SIGNED != 0)
      ? ~((c_ACC_W'(1) << (DATA_W - 1)) - c_ACC_W'(1))
      : c_ACC_W'(0);

  logic signed [c_ACC_W-1:0] acc_q, acc_d;
  logic signed [c_ACC_W-1:0] w_din_ext, w_rnd, w_trunc_sh, w_rnd_sh;
  logic                      w_ext_bit;

  // Unsigned data is zero-extended into the extra top bit, so one signed
  // datapath serves both operand flavours.
  assign w_ext_bit = (SIGNED != 0) && din[DATA_W-1];
  assign w_din_ext = {{(c_ACC_W - DATA_W){w_ext_bit}}, din};

  always_comb begin
    acc_d = acc_q;
    if (en) begin
      if (load) begin
        acc_d = w_din_ext;
      end else if (mode == MODE_MAX) begin
        acc_d = (w_din_ext > acc_q) ? w_din_ext : acc_q;
      end else begin
        acc_d = acc_q + w_din_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign w_rnd      = acc_q + c_HALF;
  assign w_trunc_sh = acc_q >>> c_SHIFT;
  assign w_rnd_sh   = w_rnd >>> c_SHIFT;

  always_comb begin
    result = acc_q[DATA_W-1:0];
    case (mode)
      MODE_MEAN_TRUNC: result = w_trunc_sh[DATA_W-1:0];
      MODE_MEAN_RND:   result = w_rnd_sh[DATA_W-1:0];
      MODE_SUM_SAT: begin
        if (acc_q > c_SAT_HI) begin
          result = c_SAT_HI[DATA_W-1:0];
        end else if (acc_q < c_SAT_LO) begin
          result = c_SAT_LO[DATA_W-1:0];
        end
      end
      default:         result = acc_q[DATA_W-1:0];
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/reduce_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reduce_param: reduces a ROWS x COLS matrix to a COLS vector, column by column. Rev 1.0
// ---------------------------------------------------------------------------
module reduce_param
  import reduce_pkg::*;
#(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int DATA_W = 8,
  parameter int SIGNED = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [1:0]                             mode,
  input  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  matrix_in,
  output logic                                   busy,
  output logic                                   done,
  output logic [COLS-1:0][DATA_W-1:0]            matrix_out
);
  localparam int c_ROW_W = $clog2(ROWS);
  localparam int c_COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  generate
    if (ROWS < 2 || (ROWS & (ROWS - 1)) != 0 || COLS < 1) begin : g_param_check
      $error("reduce_param: ROWS must be a power of two >= 2 and COLS >= 1");
    end
  endgenerate

  reduce_state_t       state_q, state_d;
  reduce_mode_t        mode_q, mode_d;
  logic [c_ROW_W-1:0]  row_q, row_d;
  logic [c_COL_W-1:0]  col_q, col_d;
  logic [DATA_W-1:0]   w_elem, w_result;
  logic                w_last_row, w_last_col;

  assign w_elem     = matrix_in[row_q][col_q];
  assign w_last_row = (row_q == c_ROW_W'(ROWS - 1));
  assign w_last_col = (col_q == c_COL_W'(COLS - 1));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACC;
          mode_d  = reduce_mode_t'(mode);
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_ACC: begin
        if (w_last_row) begin
          state_d = ST_WRITE;
        end else begin
          row_d = row_q + c_ROW_W'(1);
        end
      end
      ST_WRITE: begin
        if (w_last_col) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACC;
          col_d   = col_q + c_COL_W'(1);
          row_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_MEAN_TRUNC;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Entries are only touched in their own WRITE cycle, so earlier results
  // stay visible until overwritten by the next run.
  always_ff @(posedge clk) begin
    if (rst) begin
      matrix_out <= '0;
    end else if (state_q == ST_WRITE) begin
      matrix_out[col_q] <= w_result;
    end
  end

  reduce_acc #(
    .DATA_W (DATA_W),
    .ROWS   (ROWS),
    .SIGNED (SIGNED)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .load   ((state_q == ST_ACC) && (row_q == '0)),
    .en     (state_q == ST_ACC),
    .mode   (mode_q),
    .din    (w_elem),
    .result (w_result)
  );

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_reduce_param.sv
`timescale 1ns/1ps
// Bench for reduce_param: three instances (16x16 unsigned, 16x16 signed, 4x3x12 unsigned)
// with a queue scoreboard fed by an arithmetic reference model.
module tb_reduce_param;

  logic   clk = 1'b0;
  longint cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic                      rst_a, st_a, bz_a, dn_a;
  logic [1:0]                md_a;
  logic [15:0][15:0][7:0]    in_a;
  logic [15:0][7:0]          out_a;
  logic                      rst_b, st_b, bz_b, dn_b;
  logic [1:0]                md_b;
  logic [15:0][15:0][7:0]    in_b;
  logic [15:0][7:0]          out_b;
  logic                      rst_p, st_p, bz_p, dn_p;
  logic [1:0]                md_p;
  logic [3:0][2:0][11:0]     in_p;
  logic [2:0][11:0]          out_p;

  reduce_param #(.ROWS(16), .COLS(16), .DATA_W(8), .SIGNED(0)) u_dut_a (
    .clk(clk), .rst(rst_a), .start(st_a), .mode(md_a), .matrix_in(in_a),
    .busy(bz_a), .done(dn_a), .matrix_out(out_a));
  reduce_param #(.ROWS(16), .COLS(16), .DATA_W(8), .SIGNED(1)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(st_b), .mode(md_b), .matrix_in(in_b),
    .busy(bz_b), .done(dn_b), .matrix_out(out_b));
  reduce_param #(.ROWS(4), .COLS(3), .DATA_W(12), .SIGNED(0)) u_dut_p (
    .clk(clk), .rst(rst_p), .start(st_p), .mode(md_p), .matrix_in(in_p),
    .busy(bz_p), .done(dn_p), .matrix_out(out_p));

  int mat  [3][16][16];
  int last [3][16];
  longint dq0[$], dq1[$], dq2[$];
  int     vq0[$], vq1[$], vq2[$];
  longint kk;

  function automatic int nr(int w); return (w == 2) ? 4 : 16; endfunction
  function automatic int nc(int w); return (w == 2) ? 3 : 16; endfunction
  function automatic int dw(int w); return (w == 2) ? 12 : 8; endfunction
  function automatic bit sg(int w); return (w == 1); endfunction

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic done_of(int w);
    case (w) 0: return dn_a; 1: return dn_b; default: return dn_p; endcase
  endfunction
  function automatic logic busy_of(int w);
    case (w) 0: return bz_a; 1: return bz_b; default: return bz_p; endcase
  endfunction
  function automatic int out_of(int w, int c);
    case (w)
      0:       return int'(out_a[4'(c)]);
      1:       return int'(out_b[4'(c)]);
      default: return int'(out_p[2'(c)]);
    endcase
  endfunction

  function automatic void push_due(int w, longint d);
    case (w) 0: dq0.push_back(d); 1: dq1.push_back(d); default: dq2.push_back(d); endcase
  endfunction
  function automatic void push_val(int w, int v);
    case (w) 0: vq0.push_back(v); 1: vq1.push_back(v); default: vq2.push_back(v); endcase
  endfunction
  function automatic int qsize(int w);
    case (w) 0: return dq0.size(); 1: return dq1.size(); default: return dq2.size(); endcase
  endfunction
  function automatic longint pop_due(int w);
    case (w) 0: return dq0.pop_front(); 1: return dq1.pop_front(); default: return dq2.pop_front(); endcase
  endfunction
  function automatic int pop_val(int w);
    case (w) 0: return vq0.pop_front(); 1: return vq1.pop_front(); default: return vq2.pop_front(); endcase
  endfunction
  function automatic void qflush(int w);
    case (w)
      0:       begin dq0.delete(); vq0.delete(); end
      1:       begin dq1.delete(); vq1.delete(); end
      default: begin dq2.delete(); vq2.delete(); end
    endcase
  endfunction

  function automatic longint fdiv(longint a, longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Reference: mean = floor(sum/ROWS), rounded mean = floor((sum+ROWS/2)/ROWS),
  // max = largest element, sum clamped into the DATA_W range.
  function automatic int ref_col(int w, int c, int md);
    longint s, mx, x, r, lo, hi, n, span;
    s = 0; mx = 0; n = nr(w);
    span = longint'(1) << dw(w);
    for (int i = 0; i < n; i++) begin
      x = longint'(mat[w][i][c]);
      if (sg(w) && x >= span / 2) x = x - span;
      s = s + x;
      if (i == 0 || x > mx) mx = x;
    end
    lo = sg(w) ? -(span / 2) : 0;
    hi = sg(w) ? (span / 2) - 1 : span - 1;
    case (md)
      0:       r = fdiv(s, n);
      1:       r = fdiv(s + n / 2, n);
      2:       r = mx;
      default: r = (s > hi) ? hi : ((s < lo) ? lo : s);
    endcase
    return int'(r & (span - 1));
  endfunction

  task automatic apply(int w);
    for (int r = 0; r < nr(w); r++)
      for (int c = 0; c < nc(w); c++)
        case (w)
          0:       in_a[4'(r)][4'(c)] = 8'(mat[0][r][c]);
          1:       in_b[4'(r)][4'(c)] = 8'(mat[1][r][c]);
          default: in_p[2'(r)][2'(c)] = 12'(mat[2][r][c]);
        endcase
  endtask

  task automatic fill_rand(int w);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        mat[w][r][c] = int'($urandom_range(0, (1 << dw(w)) - 1));
  endtask

  task automatic set_start(int w, logic s, int md);
    case (w)
      0:       begin st_a = s; md_a = 2'(md); end
      1:       begin st_b = s; md_b = 2'(md); end
      default: begin st_p = s; md_p = 2'(md); end
    endcase
  endtask

  // Called at the negedge where start is high and the DUT is idle.
  function automatic void expect_run(int w, int md);
    push_due(w, cyc + 1 + nc(w) * (nr(w) + 1));
    for (int c = 0; c < nc(w); c++) push_val(w, ref_col(w, c, md));
  endfunction

  task automatic launch(int w, int md, output longint k);
    apply(w);
    @(negedge clk);
    set_start(w, 1'b1, md);
    expect_run(w, md);
    k = cyc + 1;
    @(negedge clk);
    set_start(w, 1'b0, md);
  endtask

  task automatic wait_done(int w);
    int n, budget;
    n = 0;
    budget = nc(w) * (nr(w) + 1) + 20;
    while (!done_of(w) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done_of(w)) chk($sformatf("w%0d_done_timeout", w), 0, 1);
  endtask

  task automatic chk_reset(int w, string tag);
    chk($sformatf("%s_busy", tag), longint'(busy_of(w)), 0);
    chk($sformatf("%s_done", tag), longint'(done_of(w)), 0);
    for (int c = 0; c < nc(w); c++) chk($sformatf("%s_out%0d", tag, c), out_of(w, c), 0);
  endtask

  function automatic void on_done(int w);
    longint d;
    int v;
    if (qsize(w) == 0) begin
      chk($sformatf("w%0d_spurious_done", w), 1, 0);
    end else begin
      d = pop_due(w);
      chk($sformatf("w%0d_done_cycle", w), cyc, d);
      for (int c = 0; c < nc(w); c++) begin
        v = pop_val(w);
        chk($sformatf("w%0d_col%0d", w, c), out_of(w, c), v);
        last[w][c] = v;
      end
    end
  endfunction

  always @(negedge clk) begin
    for (int w = 0; w < 3; w++) if (done_of(w)) on_done(w);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_p = 1'b1;
    for (int w = 0; w < 3; w++) begin
      set_start(w, 1'b0, 0);
      for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) mat[w][r][c] = 0;
      for (int c = 0; c < 16; c++) last[w][c] = 0;
      apply(w);
    end
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) chk_reset(w, $sformatf("w%0d_por", w));
    rst_a = 1'b0; rst_b = 1'b0; rst_p = 1'b0;

    // Plain truncating mean, one bright column.
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) mat[0][r][c] = (c == 3) ? 255 : 15;
    launch(0, 0, kk);
    wait_done(0);
    chk("t1_latency", cyc - kk, 272);
    chk("t1_col3", out_of(0, 3), 255);
    chk("t1_col0", out_of(0, 0), 15);
    @(negedge clk);
    chk("t1_busy_after_done", longint'(bz_a), 0);
    chk("t1_done_after_done", longint'(dn_a), 0);

    // Truncating vs rounding mean.
    fill_rand(0);
    for (int r = 0; r < 16; r++) begin
      mat[0][r][0] = r;
      mat[0][r][1] = (r == 7) ? 8 : 0;
    end
    launch(0, 0, kk);
    wait_done(0);
    chk("t2_trunc_ramp", out_of(0, 0), 7);
    chk("t2_trunc_one8", out_of(0, 1), 0);
    launch(0, 1, kk);
    wait_done(0);
    chk("t2_rnd_ramp", out_of(0, 0), 8);
    chk("t2_rnd_one8", out_of(0, 1), 1);

    // Signed maximum.
    fill_rand(1);
    for (int r = 0; r < 16; r++) begin
      mat[1][r][5] = (r == 9) ? 'hFF : 'h80;
      mat[1][r][6] = 'h80;
    end
    launch(1, 2, kk);
    wait_done(1);
    chk("t3_max_neg1", out_of(1, 5), 'hFF);
    chk("t3_max_all80", out_of(1, 6), 'h80);

    // Saturating sums.
    fill_rand(0);
    for (int r = 0; r < 16; r++) begin
      mat[0][r][0] = 20;
      mat[0][r][1] = 1;
    end
    launch(0, 3, kk);
    wait_done(0);
    chk("t4_sat_hi", out_of(0, 0), 255);
    chk("t4_sum16", out_of(0, 1), 16);
    fill_rand(1);
    for (int r = 0; r < 16; r++) mat[1][r][0] = 'hF0;
    launch(1, 3, kk);
    wait_done(1);
    chk("t4_sat_lo", out_of(1, 0), 'h80);

    // Random patterns in every mode on every instance.
    for (int i = 0; i < 8; i++) begin
      for (int w = 0; w < 3; w++) begin
        fill_rand(w);
        launch(w, i % 4, kk);
        wait_done(w);
      end
    end

    // Start/mode noise while busy; start on DONE ignored, next cycle accepted.
    fill_rand(0);
    launch(0, 1, kk);
    repeat (3) @(negedge clk);
    for (int c = 0; c < 16; c++) chk($sformatf("t5_retain%0d", c), out_of(0, c), last[0][c]);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      st_a = 1'($urandom_range(0, 1));
      md_a = 2'($urandom_range(0, 3));
    end
    st_a = 1'b0;
    wait_done(0);
    chk("t5_latency", cyc - kk, 272);
    set_start(0, 1'b1, 2);
    @(negedge clk);
    chk("t5_start_on_done_ignored", longint'(bz_a), 0);
    expect_run(0, 2);
    kk = cyc + 1;
    @(negedge clk);
    set_start(0, 1'b0, 0);
    chk("t5_restart_busy", longint'(bz_a), 1);
    wait_done(0);
    chk("t5_restart_latency", cyc - kk, 272);
    repeat (10) @(negedge clk);
    for (int c = 0; c < 16; c++) chk($sformatf("t5_hold%0d", c), out_of(0, c), last[0][c]);

    // Reset mid-run, then a clean run.
    fill_rand(0);
    launch(0, int'($urandom_range(0, 3)), kk);
    repeat (99) @(negedge clk);
    rst_a = 1'b1;
    qflush(0);
    @(negedge clk);
    chk_reset(0, "t6_rst");
    rst_a = 1'b0;
    repeat (300) @(negedge clk);
    launch(0, 1, kk);
    wait_done(0);
    chk("t6_latency", cyc - kk, 272);

    fill_rand(2);
    launch(2, 3, kk);
    repeat (6) @(negedge clk);
    rst_p = 1'b1;
    qflush(2);
    @(negedge clk);
    chk_reset(2, "t6p_rst");
    rst_p = 1'b0;
    repeat (30) @(negedge clk);
    launch(2, 1, kk);
    wait_done(2);
    chk("t6p_latency", cyc - kk, 15);

    repeat (5) @(negedge clk);
    chk("pending_expectations", qsize(0) + qsize(1) + qsize(2), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
